// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data side has priority; a run counter bounds how long fetch can be starved.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        owner
);

    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BUSY_I = 2'b01,
        S_BUSY_D = 2'b10
    } state_t;

    state_t             r_state;
    logic [RUN_W-1:0]   r_run;
    logic               r_cancel;

    logic               w_run_lt_max;
    logic               w_grant_d;
    logic               w_grant_i;

    // D wins unless fetch has been waiting for MAX_D_RUN data grants
    assign w_run_lt_max = (r_run < RUN_W'(MAX_D_RUN));
    assign w_grant_d    = d_req & (~i_req | w_run_lt_max);
    assign w_grant_i    = ~w_grant_d & i_req & ~i_cancel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_cancel  <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_grant_d) begin
                        r_state   <= S_BUSY_D;
                        mem_req   <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_we    <= d_we;
                        if (!i_req) begin
                            r_run <= '0;
                        end else if (w_run_lt_max) begin
                            r_run <= r_run + 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state   <= S_BUSY_I;
                        mem_req   <= 1'b1;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                        r_run     <= '0;
                    end else if (!i_req) begin
                        r_run <= '0;
                    end
                end
                S_BUSY_I: begin
                    // memory cannot abort, so a jump only suppresses the response
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_cancel  <= 1'b0;
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                    end else if (i_cancel) begin
                        r_cancel <= 1'b1;
                    end
                end
                S_BUSY_D: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // response strobes are same-cycle with mem_ack
    assign i_valid = (r_state == S_BUSY_I) & mem_ack & ~r_cancel & ~i_cancel;
    assign d_valid = (r_state == S_BUSY_D) & mem_ack;
    assign i_rdata = i_valid ? mem_rdata : '0;
    assign d_rdata = d_valid ? mem_rdata : '0;
    assign owner   = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, arbitration fairness, store,
// fetch cancel, async reset and spurious acknowledge.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_cancel;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_we;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; i_cancel = 1'b0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        step();
        step();
        checks++;
        if ({mem_req, mem_we, owner} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b we=%b owner=%b exp 0 0 00", mem_req, mem_we, owner);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_valid, d_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes got i=%b d=%b exp 0 0", i_valid, d_valid);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 64'h100;
        step();
        checks++;
        if ({mem_req, mem_we, owner} !== 4'b1001 || mem_addr !== 64'h100) begin
            errors++;
            $display("FAIL fetch_grant got req=%b we=%b owner=%b addr=%h exp 1 0 01 100",
                     mem_req, mem_we, owner, mem_addr);
        end
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
        #1;
        checks++;
        if (i_valid !== 1'b1 || i_rdata !== 64'hDEADBEEF || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp got iv=%b rdata=%h dv=%b exp 1 deadbeef 0", i_valid, i_rdata, d_valid);
        end
        step();
        i_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if (owner !== 2'b00 || mem_req !== 1'b0 || mem_addr !== 64'h0 || i_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle got owner=%b req=%b addr=%h iv=%b exp 00 0 0 0", owner, mem_req, mem_addr, i_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_order [10];
        int waited;
        exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h800;
        i_req = 1'b1; i_addr = 64'h900;
        for (int k = 0; k < 10; k++) begin
            waited = 0;
            step();
            while (!mem_req && waited < 8) begin
                step();
                waited++;
            end
            checks++;
            if (waited != 0 || owner !== exp_order[k]) begin
                errors++;
                $display("FAIL b2b_grant%0d got owner=%b after %0d extra cycles exp %b after 0",
                         k, owner, waited, exp_order[k]);
            end
            step();
            mem_ack = 1'b1;
            #1;
            checks++;
            if ({i_valid, d_valid} !== {exp_order[k] == 2'b01, exp_order[k] == 2'b10}) begin
                errors++;
                $display("FAIL b2b_strobe%0d got iv=%b dv=%b exp owner %b", k, i_valid, d_valid, exp_order[k]);
            end
            step();
            mem_ack = 1'b0;
            if (k == 9) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            #1;
            checks++;
            if (owner !== 2'b00 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap%0d got owner=%b req=%b exp 00 0", k, owner, mem_req);
            end
        end
        step();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_addr = 64'h2000; d_wdata = 64'h55AA; d_we = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_we, owner} !== 4'b1110 || mem_addr !== 64'h2000 || mem_wdata !== 64'h55AA) begin
            errors++;
            $display("FAIL store_grant got req=%b we=%b owner=%b addr=%h wdata=%h exp 1 1 10 2000 55aa",
                     mem_req, mem_we, owner, mem_addr, mem_wdata);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, d_valid} !== {1'b1, 1'b1, 64'h2000, 64'h55AA, 1'b0}) begin
                errors++;
                $display("FAIL store_hold%0d got req=%b we=%b addr=%h wdata=%h dv=%b exp 1 1 2000 55aa 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, d_valid);
            end
        end
        mem_ack = 1'b1; mem_rdata = 64'hCAFE;
        #1;
        checks++;
        if (d_valid !== 1'b1 || i_valid !== 1'b0 || d_rdata !== 64'hCAFE) begin
            errors++;
            $display("FAIL store_resp got dv=%b iv=%b rdata=%h exp 1 0 cafe", d_valid, i_valid, d_rdata);
        end
        step();
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({d_valid, owner, mem_we, mem_req} !== 5'b00000 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL store_done got dv=%b owner=%b we=%b req=%b wdata=%h exp 0 00 0 0 0",
                     d_valid, owner, mem_we, mem_req, mem_wdata);
        end
        step();
    endtask

    task automatic test_cancel();
        i_req = 1'b1; i_addr = 64'h300;
        step();
        checks++;
        if (owner !== 2'b01 || mem_addr !== 64'h300) begin
            errors++;
            $display("FAIL cancel_grant got owner=%b addr=%h exp 01 300", owner, mem_addr);
        end
        step();
        i_cancel = 1'b1; i_req = 1'b0;
        step();
        i_cancel = 1'b0;
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        #1;
        checks++;
        if (i_valid !== 1'b0 || i_rdata !== 64'h0) begin
            errors++;
            $display("FAIL cancel_suppress got iv=%b rdata=%h exp 0 0", i_valid, i_rdata);
        end
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if (owner !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle got owner=%b req=%b exp 00 0", owner, mem_req);
        end
        i_req = 1'b1; i_addr = 64'h400;
        step();
        checks++;
        if (mem_req !== 1'b1 || owner !== 2'b01 || mem_addr !== 64'h400) begin
            errors++;
            $display("FAIL cancel_refetch got req=%b owner=%b addr=%h exp 1 01 400", mem_req, owner, mem_addr);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 64'h4444;
        #1;
        checks++;
        if (i_valid !== 1'b1 || i_rdata !== 64'h4444) begin
            errors++;
            $display("FAIL cancel_refetch_resp got iv=%b rdata=%h exp 1 4444", i_valid, i_rdata);
        end
        step();
        i_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step();
    endtask

    task automatic test_async_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h5000;
        step();
        checks++;
        if (owner !== 2'b10 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_grant got owner=%b req=%b exp 10 1", owner, mem_req);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || owner !== 2'b00 || mem_addr !== 64'h0) begin
            errors++;
            $display("FAIL areset_immediate got req=%b owner=%b addr=%h exp 0 00 0", mem_req, owner, mem_addr);
        end
        d_req = 1'b0;
        step();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h99;
        #1;
        checks++;
        if ({d_valid, i_valid} !== 2'b00 || d_rdata !== 64'h0) begin
            errors++;
            $display("FAIL areset_late_ack got dv=%b iv=%b rdata=%h exp 0 0 0", d_valid, i_valid, d_rdata);
        end
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if (owner !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle got owner=%b req=%b exp 00 0", owner, mem_req);
        end
    endtask

    task automatic test_spurious_ack();
        step();
        mem_ack = 1'b1; mem_rdata = 64'h77;
        #1;
        checks++;
        if ({i_valid, d_valid} !== 2'b00 || {i_rdata, d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL spurious_strobe got iv=%b dv=%b ird=%h drd=%h exp 0 0 0 0",
                     i_valid, d_valid, i_rdata, d_rdata);
        end
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if (owner !== 2'b00 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_state got owner=%b req=%b exp 00 0", owner, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store();
        test_cancel();
        test_async_reset();
        test_spurious_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
